distance_8cen_accum: RTL and testbench



---
 rtl/distance_8cen_accum_if.sv | 28 ++
 rtl/distance_8cen_accum.sv | 101 ++++++++++
 tb/tb_distance_8cen_accum.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/distance_8cen_accum_if.sv
`default_nettype none
// ============================================================================
// distance_8cen_accum_if : beat-in / distance-set-out handshake bundle
// Revision 1.0
// ============================================================================
interface distance_8cen_accum_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      x;
    logic [15:0]      c_000, c_001, c_010, c_011, c_100, c_101, c_110, c_111;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      d_000, d_001, d_010, d_011, d_100, d_101, d_110, d_111;
    logic [CNT_W-1:0] elem_cnt;

    modport master (
        output in_valid, x, c_000, c_001, c_010, c_011, c_100, c_101, c_110, c_111, out_ready,
        input  in_ready, out_valid, d_000, d_001, d_010, d_011, d_100, d_101, d_110, d_111, elem_cnt
    );

    modport slave (
        input  in_valid, x, c_000, c_001, c_010, c_011, c_100, c_101, c_110, c_111, out_ready,
        output in_ready, out_valid, d_000, d_001, d_010, d_011, d_100, d_101, d_110, d_111, elem_cnt
    );
endinterface
`default_nettype wire

// File: rtl/distance_8cen_accum.sv
`default_nettype none
// ============================================================================
// distance_8cen_accum : saturating L1 distance of one vector to 8 centroids
// Revision 1.0
// ============================================================================
module distance_8cen_accum #(
    parameter int DIM   = 16,
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    distance_8cen_accum_if.slave  bus
);
    localparam int               c_LANES    = 8;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DIM - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      w_c   [c_LANES];
    logic [15:0]      w_acc [c_LANES];
    logic [15:0]      r_d   [c_LANES];
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_zero;

    assign w_c[0] = bus.c_000;
    assign w_c[1] = bus.c_001;
    assign w_c[2] = bus.c_010;
    assign w_c[3] = bus.c_011;
    assign w_c[4] = bus.c_100;
    assign w_c[5] = bus.c_101;
    assign w_c[6] = bus.c_110;
    assign w_c[7] = bus.c_111;

    assign w_accept = bus.in_valid & (r_state == ST_ACCUM);
    assign w_last   = (r_cnt == c_LAST_CNT);
    assign w_zero   = clear | ((r_state == ST_DONE) & bus.out_ready);

    // 17-bit sum per lane; the carry bit pins the lane at full scale
    for (genvar k = 0; k < c_LANES; k++) begin : g_lane
        logic [15:0] w_diff;
        logic [16:0] w_sum;
        assign w_diff   = (bus.x >= w_c[k]) ? (bus.x - w_c[k]) : (w_c[k] - bus.x);
        assign w_sum    = {1'b0, r_d[k]} + {1'b0, w_diff};
        assign w_acc[k] = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_DONE;
                ST_DONE:  if (bus.out_ready)      w_state_nxt = ST_ACCUM;
                default:                          w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int k = 0; k < c_LANES; k++) r_d[k] <= '0;
        end else if (w_zero) begin
            r_cnt <= '0;
            for (int k = 0; k < c_LANES; k++) r_d[k] <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            for (int k = 0; k < c_LANES; k++) r_d[k] <= w_acc[k];
        end
    end

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.elem_cnt  = r_cnt;
    assign bus.d_000     = r_d[0];
    assign bus.d_001     = r_d[1];
    assign bus.d_010     = r_d[2];
    assign bus.d_011     = r_d[3];
    assign bus.d_100     = r_d[4];
    assign bus.d_101     = r_d[5];
    assign bus.d_110     = r_d[6];
    assign bus.d_111     = r_d[7];
endmodule
`default_nettype wire

// File: tb/tb_distance_8cen_accum.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_distance_8cen_accum : directed + randomized checks against an L1 model
// Revision 1.0
// ============================================================================
module tb_distance_8cen_accum;
    localparam int DIM   = 4;
    localparam int CNT_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [15:0] vx [DIM];
    logic [15:0] vc [DIM][8];

    distance_8cen_accum_if #(.CNT_W(CNT_W)) bus ();

    distance_8cen_accum #(.DIM(DIM), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: saturated sum of absolute differences over the first n beats
    function automatic logic [15:0] model_dist(int k, int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            s += (vx[i] >= vc[i][k]) ? (int'(vx[i]) - int'(vc[i][k])) : (int'(vc[i][k]) - int'(vx[i]));
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    function automatic logic [15:0] get_d(int k);
        case (k)
            0: return bus.d_000;
            1: return bus.d_001;
            2: return bus.d_010;
            3: return bus.d_011;
            4: return bus.d_100;
            5: return bus.d_101;
            6: return bus.d_110;
            default: return bus.d_111;
        endcase
    endfunction

    task automatic drive_c(input logic [15:0] c [8]);
        bus.c_000 = c[0]; bus.c_001 = c[1]; bus.c_010 = c[2]; bus.c_011 = c[3];
        bus.c_100 = c[4]; bus.c_101 = c[5]; bus.c_110 = c[6]; bus.c_111 = c[7];
    endtask

    task automatic drive_junk();
        logic [15:0] c [8];
        for (int k = 0; k < 8; k++) c[k] = 16'($urandom);
        bus.x = 16'($urandom);
        drive_c(c);
    endtask

    task automatic set_beat(input int i);
        bus.x = vx[i];
        drive_c(vc[i]);
    endtask

    // Drives beats first..first+n-1, optionally with an idle cycle before each
    task automatic feed(input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                drive_junk();
                @(posedge clk); #1;
            end
            set_beat(i);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        drive_junk();
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic rand_vec();
        int mode = int'($urandom_range(0, 2));
        for (int i = 0; i < DIM; i++) begin
            vx[i] = (mode == 1) ? 16'($urandom_range(0, 1023)) : 16'($urandom);
            for (int k = 0; k < 8; k++)
                vc[i][k] = (mode == 1 || (mode == 2 && k < 4)) ? 16'($urandom_range(0, 1023)) : 16'($urandom);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.elem_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b elem_cnt=%0d, want 1 0 0", bus.in_ready, bus.out_valid, bus.elem_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_d%0d: got %h want 0000", k, get_d(k));
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_l1();
        logic [15:0] c7 [DIM];
        c7 = '{16'd12, 16'd18, 16'd33, 16'd37};
        for (int i = 0; i < DIM; i++) begin
            vx[i] = 16'(10 * (i + 1));
            for (int k = 0; k < 8; k++) vc[i][k] = 16'h0;
            vc[i][0] = vx[i];
            vc[i][7] = c7[i];
        end
        feed(0, DIM - 1, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.elem_cnt !== CNT_W'(DIM - 1)) begin
            n_fail++;
            $display("FAIL basic_partial: out_valid=%b elem_cnt=%0d, want 0 %0d", bus.out_valid, bus.elem_cnt, DIM - 1);
        end
        feed(DIM - 1, 1, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.elem_cnt !== CNT_W'(DIM)) begin
            n_fail++;
            $display("FAIL basic_done: out_valid=%b in_ready=%b elem_cnt=%0d, want 1 0 %0d", bus.out_valid, bus.in_ready, bus.elem_cnt, DIM);
        end
        n_tests++;
        if (bus.d_000 !== 16'd0 || bus.d_001 !== 16'd100 || bus.d_111 !== 16'd10) begin
            n_fail++;
            $display("FAIL basic_l1: d000=%0d d001=%0d d111=%0d, want 0 100 10", bus.d_000, bus.d_001, bus.d_111);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== model_dist(k, DIM)) begin
                n_fail++;
                $display("FAIL basic_d%0d: got %0d want %0d", k, get_d(k), model_dist(k, DIM));
            end
        end
        consume();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.elem_cnt !== '0 || bus.d_001 !== 16'h0) begin
            n_fail++;
            $display("FAIL basic_consume: in_ready=%b out_valid=%b elem_cnt=%0d d001=%0d, want 1 0 0 0", bus.in_ready, bus.out_valid, bus.elem_cnt, bus.d_001);
        end
    endtask

    task automatic test_saturation();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DIM; i++) begin
                vx[i] = (pass == 0) ? 16'hFFFF : 16'h4000;
                for (int k = 0; k < 8; k++) vc[i][k] = 16'h0;
            end
            feed(0, DIM - 1, 1'b0);
            for (int k = 0; k < 8; k++) begin
                n_tests++;
                if (get_d(k) !== ((pass == 0) ? 16'hFFFF : 16'hC000)) begin
                    n_fail++;
                    $display("FAIL sat%0d_3beats_d%0d: got %h want %h", pass, k, get_d(k), (pass == 0) ? 16'hFFFF : 16'hC000);
                end
            end
            feed(DIM - 1, 1, 1'b0);
            for (int k = 0; k < 8; k++) begin
                n_tests++;
                if (get_d(k) !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL sat%0d_final_d%0d: got %h want ffff", pass, k, get_d(k));
                end
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        rand_vec();
        feed(0, DIM, 1'b0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b0;
            drive_junk();
            @(posedge clk); #1;
            n_tests++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.elem_cnt !== CNT_W'(DIM)) begin
                n_fail++;
                $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b elem_cnt=%0d, want 0 1 %0d", cyc, bus.in_ready, bus.out_valid, bus.elem_cnt, DIM);
            end
            for (int k = 0; k < 8; k++) begin
                n_tests++;
                if (get_d(k) !== model_dist(k, DIM)) begin
                    n_fail++;
                    $display("FAIL bp_stable%0d_d%0d: got %0d want %0d", cyc, k, get_d(k), model_dist(k, DIM));
                end
            end
        end
        consume();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.elem_cnt !== '0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b elem_cnt=%0d, want 1 0 0", bus.in_ready, bus.out_valid, bus.elem_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== 16'h0) begin
                n_fail++;
                $display("FAIL bp_zero_d%0d: got %h want 0000", k, get_d(k));
            end
        end
    endtask

    task automatic test_bubbles();
        rand_vec();
        feed(0, 2, 1'b1);
        n_tests++;
        if (bus.elem_cnt !== CNT_W'(2)) begin
            n_fail++;
            $display("FAIL bubble_cnt: got %0d want 2", bus.elem_cnt);
        end
        feed(2, DIM - 2, 1'b1);
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bubble_done: out_valid=%b want 1", bus.out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== model_dist(k, DIM)) begin
                n_fail++;
                $display("FAIL bubble_d%0d: got %0d want %0d", k, get_d(k), model_dist(k, DIM));
            end
        end
        consume();
    endtask

    task automatic test_clear();
        rand_vec();
        feed(0, 2, 1'b0);
        set_beat(2);
        bus.in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.elem_cnt !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_accum: elem_cnt=%0d in_ready=%b out_valid=%b, want 0 1 0", bus.elem_cnt, bus.in_ready, bus.out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== 16'h0) begin
                n_fail++;
                $display("FAIL clear_accum_d%0d: got %h want 0000", k, get_d(k));
            end
        end
        feed(0, DIM, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== model_dist(k, DIM)) begin
                n_fail++;
                $display("FAIL clear_fresh_d%0d: got %0d want %0d", k, get_d(k), model_dist(k, DIM));
            end
        end
        clear = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.elem_cnt !== '0 || bus.d_011 !== 16'h0) begin
            n_fail++;
            $display("FAIL clear_done: out_valid=%b in_ready=%b elem_cnt=%0d d011=%h, want 0 1 0 0000", bus.out_valid, bus.in_ready, bus.elem_cnt, bus.d_011);
        end
    endtask

    task automatic test_async_reset();
        rand_vec();
        feed(0, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.elem_cnt !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_ctrl: elem_cnt=%0d out_valid=%b in_ready=%b, want 0 0 1", bus.elem_cnt, bus.out_valid, bus.in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== 16'h0) begin
                n_fail++;
                $display("FAIL areset_d%0d: got %h want 0000", k, get_d(k));
            end
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_vec();
        feed(0, DIM, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (get_d(k) !== model_dist(k, DIM)) begin
                n_fail++;
                $display("FAIL areset_after_d%0d: got %0d want %0d", k, get_d(k), model_dist(k, DIM));
            end
        end
        consume();
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            rand_vec();
            feed(0, DIM, 1'($urandom_range(0, 1)));
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.elem_cnt !== CNT_W'(DIM)) begin
                n_fail++;
                $display("FAIL rand%0d_done: out_valid=%b elem_cnt=%0d, want 1 %0d", it, bus.out_valid, bus.elem_cnt, DIM);
            end
            for (int k = 0; k < 8; k++) begin
                n_tests++;
                if (get_d(k) !== model_dist(k, DIM)) begin
                    n_fail++;
                    $display("FAIL rand%0d_d%0d: got %0d want %0d", it, k, get_d(k), model_dist(k, DIM));
                end
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            consume();
            n_tests++;
            if (bus.elem_cnt !== '0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_consume: elem_cnt=%0d in_ready=%b, want 0 1", it, bus.elem_cnt, bus.in_ready);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_junk();
        test_reset();
        test_basic_l1();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
